// File: rtl/adder_ctrl_pkg.sv
// rtl/adder_ctrl_pkg.sv - shared types and constants for the digit-serial adder
// Holds the controller state encoding and the digit width used by the datapath.
package adder_ctrl_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_slice_2b.sv
// rtl/adder_slice_2b.sv - combinational 2-bit full-adder slice
// Ports:
//   x, y : 2-bit digit operands
//   ci   : carry into the slice
//   s    : 2-bit digit sum
//   co   : carry out of the slice
module adder_slice_2b (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {2'b00, ci};

endmodule

// File: rtl/digit_serial_adder_ctrl.sv
// rtl/digit_serial_adder_ctrl.sv - digit-serial adder controller, one 2-bit digit per cycle
// Ports:
//   clk, rst_n           : clock and synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
//   busy                 : high while an operation is in flight or waiting to be taken
module digit_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  // Keep the counter at least one bit wide so WIDTH=2 still elaborates.
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic [1:0] dig_s;
  logic       dig_co;

  // Single shared slice; the counter steers which digit it sees each cycle.
  adder_slice_2b u_slice (
    .x  (a_q[DIGIT_W*cnt_q +: DIGIT_W]),
    .y  (b_q[DIGIT_W*cnt_q +: DIGIT_W]),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;  // carry-in seeds the digit chain
            cnt_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[DIGIT_W*cnt_q +: DIGIT_W] <= dig_s;
          carry_q <= dig_co;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule
